// File: rtl/act_pkg.sv
// act_pkg: shared state type, default sizes and saturating add for the
// switching-activity monitor (optional 1->0 counting via ACT_FALL_EN).
package act_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        REPORT
    } act_state_t;

    localparam int ACT_N_NETS = 8;
    localparam int ACT_CNT_W  = 16;
    localparam int ACT_WIN_W  = 8;

    // Clamp acc+inc to maxv; counters up to 31 bits wide.
    function automatic logic [31:0] sat_add(
        input logic [31:0] acc,
        input logic [31:0] inc,
        input logic [31:0] maxv
    );
        logic [32:0] sum;
        sum = {1'b0, acc} + {1'b0, inc};
        return (sum > {1'b0, maxv}) ? maxv : sum[31:0];
    endfunction

endpackage

// File: rtl/act_edge_count.sv
// act_edge_count: per-cycle transition popcount between two net samples.
// Counts 0->1 only, or all toggles when ACT_FALL_EN is defined.
module act_edge_count
    import act_pkg::*;
#(
    parameter int N_NETS = ACT_N_NETS,
    parameter int PC_W   = $clog2(N_NETS + 1)
) (
    input  logic [N_NETS-1:0] nets,
    input  logic [N_NETS-1:0] prev,
    output logic [PC_W-1:0]   count
);

    logic [N_NETS-1:0] edges;

`ifdef ACT_FALL_EN
    assign edges = nets ^ prev;
`else
    assign edges = nets & ~prev;
`endif

    // An X bit fails the if test, so unknown nets count as no transition.
    always_comb begin
        count = '0;
        for (int i = 0; i < N_NETS; i++) begin
            if (edges[i]) count = count + PC_W'(1);
        end
    end

endmodule

// File: rtl/activity_monitor.sv
// activity_monitor: counts net transitions over a programmable window and
// reports a saturating total via valid/ready. Build option: ACT_FALL_EN.
module activity_monitor
    import act_pkg::*;
#(
    parameter int N_NETS = ACT_N_NETS,
    parameter int CNT_W  = ACT_CNT_W,
    parameter int WIN_W  = ACT_WIN_W
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              enable,
    input  logic [N_NETS-1:0] nets,
    input  logic [WIN_W-1:0]  win_len,
    input  logic              rpt_ready,
    output logic              rpt_valid,
    output logic [CNT_W-1:0]  rpt_count,
    output logic              rpt_overflow,
    output logic              busy
);

    localparam int PC_W = $clog2(N_NETS + 1);
    localparam logic [31:0] CNT_MAX =
        32'((33'd1 << CNT_W) - 33'd1);

    act_state_t        state_q, state_d;
    logic [N_NETS-1:0] prev_q, prev_d;
    logic [CNT_W-1:0]  acc_q, acc_d;
    logic              ovf_q, ovf_d;
    logic [WIN_W-1:0]  remain_q, remain_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rovf_q, rovf_d;

    logic [PC_W-1:0]   edges;
    logic [CNT_W:0]    sum;
    logic [CNT_W-1:0]  acc_nxt;
    logic              ovf_nxt;

    act_edge_count #(
        .N_NETS (N_NETS),
        .PC_W   (PC_W)
    ) u_edge (
        .nets   (nets),
        .prev   (prev_q),
        .count  (edges)
    );

    assign sum     = {1'b0, acc_q} + (CNT_W+1)'(edges);
    assign ovf_nxt = ovf_q | (sum > {1'b0, {CNT_W{1'b1}}});
    assign acc_nxt = CNT_W'(sat_add(32'(acc_q), 32'(edges), CNT_MAX));

    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        remain_d = remain_q;
        cnt_d    = cnt_q;
        rovf_d   = rovf_q;
        unique case (state_q)
            IDLE: begin
                if (enable && win_len != '0) begin
                    state_d  = MEASURE;
                    prev_d   = nets;
                    acc_d    = '0;
                    ovf_d    = 1'b0;
                    remain_d = win_len;
                end
            end
            MEASURE: begin
                if (!enable) begin
                    state_d = IDLE;
                end else begin
                    acc_d    = acc_nxt;
                    ovf_d    = ovf_nxt;
                    prev_d   = nets;
                    remain_d = remain_q - WIN_W'(1);
                    if (remain_q == WIN_W'(1)) begin
                        state_d = REPORT;
                        cnt_d   = acc_nxt;
                        rovf_d  = ovf_nxt;
                    end
                end
            end
            REPORT: begin
                if (rpt_ready) begin
                    if (enable && win_len != '0) begin
                        state_d  = MEASURE;
                        prev_d   = nets;
                        acc_d    = '0;
                        ovf_d    = 1'b0;
                        remain_d = win_len;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_q  <= IDLE;
            prev_q   <= '0;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
            remain_q <= '0;
            cnt_q    <= '0;
            rovf_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            acc_q    <= acc_d;
            ovf_q    <= ovf_d;
            remain_q <= remain_d;
            cnt_q    <= cnt_d;
            rovf_q   <= rovf_d;
        end
    end

    assign rpt_valid    = (state_q == REPORT);
    assign busy         = (state_q != IDLE);
    assign rpt_count    = cnt_q;
    assign rpt_overflow = rovf_q;

endmodule

// File: tb/tb_activity_monitor.sv
// tb_activity_monitor: table vectors, hand sequences and a randomized
// window model for activity_monitor (16-bit and 4-bit counter instances).
module tb_activity_monitor;

    logic        clk;
    logic        reset_L;
    logic        en_b, en_s;
    logic [7:0]  nets;
    logic [7:0]  win_len;
    logic        rpt_ready;
    logic        v_b, o_b, bz_b;
    logic [15:0] c_b;
    logic        v_s, o_s, bz_s;
    logic [3:0]  c_s;
    bit          sel;

    int n_pass = 0;
    int n_total = 0;
    int last_big = 0;

    activity_monitor u_big (
        .clk(clk), .reset_L(reset_L), .enable(en_b), .nets(nets),
        .win_len(win_len), .rpt_ready(rpt_ready), .rpt_valid(v_b),
        .rpt_count(c_b), .rpt_overflow(o_b), .busy(bz_b)
    );

    activity_monitor #(.CNT_W(4)) u_sml (
        .clk(clk), .reset_L(reset_L), .enable(en_s), .nets(nets),
        .win_len(win_len), .rpt_ready(rpt_ready), .rpt_valid(v_s),
        .rpt_count(c_s), .rpt_overflow(o_s), .busy(bz_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire        valid_m = sel ? v_s : v_b;
    wire        busy_m  = sel ? bz_s : bz_b;
    wire        ovf_m   = sel ? o_s : o_b;
    wire [15:0] count_m = sel ? {12'd0, c_s} : c_b;

    typedef struct {
        bit       sml;
        bit [7:0] win;
        bit [7:0] st;
        bit [7:0] a;
        bit [7:0] b;
        int       dly;
        int       cnt;
        bit       ovf;
    } vec_t;

    vec_t vt[9];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_en(input bit v);
        if (sel) en_s = v;
        else en_b = v;
    endtask

    function automatic int trans(input logic [7:0] p, input logic [7:0] n);
`ifdef ACT_FALL_EN
        return $countones(n ^ p);
`else
        return $countones(n & ~p);
`endif
    endfunction

    task automatic run_window(input vec_t v, input bit keep,
                              input bit started);
        sel = v.sml;
        win_len = v.win;
        rpt_ready = (v.dly == 0);
        if (!started) begin
            nets = v.st;
            set_en(1'b1);
            step();
            check("start_busy", 32'(busy_m), 32'd1);
        end
        for (int c = 0; c < int'(v.win); c++) begin
            nets = (c % 2 == 0) ? v.a : v.b;
            if (c == int'(v.win) - 1)
                check("no_early_valid", 32'(valid_m), 32'd0);
            step();
        end
        check("rpt_valid", 32'(valid_m), 32'd1);
        check("rpt_count", 32'(count_m), 32'(v.cnt));
        check("rpt_ovf", 32'(ovf_m), 32'(v.ovf));
        for (int d = 0; d < v.dly; d++) begin
            step();
            check("hold_valid", 32'(valid_m), 32'd1);
            check("hold_count", 32'(count_m), 32'(v.cnt));
        end
        rpt_ready = 1'b1;
        set_en(keep);
        step();
        check("accept_valid", 32'(valid_m), 32'd0);
        check("accept_busy", 32'(busy_m), 32'(keep));
        check("count_kept", 32'(count_m), 32'(v.cnt));
        if (!v.sml) last_big = v.cnt;
    endtask

    task automatic rand_test();
        int w, abort_at, exp, dly;
        bit seen;
        logic [7:0] prev_m;
        sel = 1'b0;
        for (int it = 0; it < 30; it++) begin
            w = $urandom_range(1, 12);
            abort_at = ($urandom_range(0, 3) == 0) ?
                       $urandom_range(0, w - 1) : -1;
            exp = 0;
            seen = 1'b0;
            win_len = 8'(w);
            nets = 8'($urandom);
            prev_m = nets;
            rpt_ready = 1'b0;
            en_b = 1'b1;
            step();
            for (int c = 0; c < w; c++) begin
                nets = 8'($urandom);
                if (c == abort_at) begin
                    en_b = 1'b0;
                    break;
                end
                exp += trans(prev_m, nets);
                prev_m = nets;
                step();
                if (c < w - 1) seen |= v_b;
            end
            if (abort_at >= 0) begin
                step();
                check("rand_abort_busy", 32'(bz_b), 32'd0);
                check("rand_abort_valid", 32'(v_b), 32'd0);
                check("rand_abort_hold", 32'(c_b), 32'(last_big));
                continue;
            end
            if (exp > 65535) exp = 65535;
            check("rand_early", 32'(seen), 32'd0);
            check("rand_valid", 32'(v_b), 32'd1);
            check("rand_count", 32'(c_b), 32'(exp));
            check("rand_ovf", 32'(o_b), 32'd0);
            last_big = exp;
            dly = $urandom_range(0, 2);
            for (int d = 0; d < dly; d++) step();
            check("rand_held", 32'(c_b), 32'(exp));
            rpt_ready = 1'b1;
            en_b = 1'b0;
            step();
            check("rand_accept", 32'(v_b), 32'd0);
        end
    endtask

    initial begin
        bit seen;
`ifdef ACT_FALL_EN
        vt[0] = '{0, 4, 8'h00, 8'hFF, 8'h00, 0, 32, 0};
        vt[1] = '{0, 4, 8'h00, 8'hFF, 8'h00, 3, 32, 0};
        vt[2] = '{0, 1, 8'h00, 8'h0F, 8'h00, 1, 4, 0};
        vt[3] = '{0, 3, 8'hFF, 8'h00, 8'hFF, 0, 24, 0};
        vt[4] = '{0, 2, 8'h0F, 8'hF0, 8'h0F, 2, 16, 0};
        vt[5] = '{0, 255, 8'h00, 8'hFF, 8'h00, 0, 2040, 0};
        vt[6] = '{1, 8, 8'h00, 8'h0F, 8'h00, 1, 15, 1};
        vt[7] = '{1, 3, 8'h00, 8'h0F, 8'h00, 0, 12, 0};
        vt[8] = '{1, 10, 8'h00, 8'h07, 8'h00, 0, 15, 1};
`else
        vt[0] = '{0, 4, 8'h00, 8'hFF, 8'h00, 0, 16, 0};
        vt[1] = '{0, 4, 8'h00, 8'hFF, 8'h00, 3, 16, 0};
        vt[2] = '{0, 1, 8'h00, 8'h0F, 8'h00, 1, 4, 0};
        vt[3] = '{0, 3, 8'hFF, 8'h00, 8'hFF, 0, 8, 0};
        vt[4] = '{0, 2, 8'h0F, 8'hF0, 8'h0F, 2, 8, 0};
        vt[5] = '{0, 255, 8'h00, 8'hFF, 8'h00, 0, 1024, 0};
        vt[6] = '{1, 8, 8'h00, 8'h0F, 8'h00, 1, 15, 1};
        vt[7] = '{1, 3, 8'h00, 8'h0F, 8'h00, 0, 8, 0};
        vt[8] = '{1, 10, 8'h00, 8'h07, 8'h00, 0, 15, 0};
`endif
        sel = 1'b0;
        reset_L = 1'b0;
        en_b = 1'b1;
        en_s = 1'b1;
        win_len = 8'd4;
        rpt_ready = 1'b1;
        nets = 8'h00;
        step();
        nets = 8'hFF;
        step();
        check("rst_valid_b", 32'(v_b), 32'd0);
        check("rst_count_b", 32'(c_b), 32'd0);
        check("rst_ovf_b", 32'(o_b), 32'd0);
        check("rst_busy_b", 32'(bz_b), 32'd0);
        check("rst_valid_s", 32'(v_s), 32'd0);
        check("rst_busy_s", 32'(bz_s), 32'd0);
        en_b = 1'b0;
        en_s = 1'b0;
        reset_L = 1'b1;
        step();

        for (int i = 0; i < 9; i++) run_window(vt[i], 1'b0, 1'b0);

        // Backpressured report accepted with enable held: next window runs.
        run_window(vt[1], 1'b1, 1'b0);
        run_window(vt[1], 1'b0, 1'b1);

        // Abort in the second MEASURE cycle.
        sel = 1'b0;
        win_len = 8'd5;
        nets = 8'h00;
        en_b = 1'b1;
        step();
        nets = 8'hFF;
        step();
        en_b = 1'b0;
        nets = 8'h00;
        step();
        check("abort_busy", 32'(bz_b), 32'd0);
        check("abort_valid", 32'(v_b), 32'd0);
        check("abort_hold", 32'(c_b), 32'(last_big));
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            nets = ~nets;
            step();
            seen |= v_b | bz_b;
        end
        check("abort_quiet", 32'(seen), 32'd0);

        // Zero-length window never leaves IDLE.
        win_len = 8'd0;
        en_b = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            nets = ~nets;
            step();
            seen |= v_b | bz_b;
        end
        check("zero_len_idle", 32'(seen), 32'd0);
        en_b = 1'b0;
        step();

        rand_test();

        // Reset while a report is pending.
        sel = 1'b0;
        win_len = 8'd2;
        nets = 8'h00;
        rpt_ready = 1'b0;
        en_b = 1'b1;
        step();
        nets = 8'hFF;
        step();
        nets = 8'h00;
        step();
        check("pre_rst_valid", 32'(v_b), 32'd1);
        reset_L = 1'b0;
        step();
        check("mid_rst_valid", 32'(v_b), 32'd0);
        check("mid_rst_count", 32'(c_b), 32'd0);
        check("mid_rst_busy", 32'(bz_b), 32'd0);
        reset_L = 1'b1;
        en_b = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/activity_monitor.md
Name: activity_monitor

Overview:
- Consumer side of the gate-level switching-activity scheme: the gate models produce 0->1 output transitions, and this block counts them as energy events.
- Samples a bus of N_NETS gate-output nets once per clock and counts rising transitions over a programmable window of cycles.
- Returns a saturating energy count through a valid/ready report handshake.
- Sits beside the structural gate netlists in the testbench or power-estimation harness; it is synthesizable.

Parameters:
- N_NETS, 8: number of monitored nets.
- CNT_W, 16: width of the accumulated transition count.
- WIN_W, 8: width of the window-length field.

Ports:
- clk  in  1  single clock, rising edge.
- reset_L  in  1  synchronous, active-low reset.
- enable  in  1  start and continue measurement.
- nets  in  N_NETS  monitored gate outputs.
- win_len  in  WIN_W  window length in cycles; sampled at window start.
- rpt_ready  in  1  consumer accepts the report.
- rpt_valid  out  1  report available.
- rpt_count  out  CNT_W  transitions counted in the window.
- rpt_overflow  out  1  count saturated during the window.
- busy  out  1  high in MEASURE or REPORT.

Behaviour:
- Reset (reset_L=0 at a clk edge): state=IDLE; rpt_valid=0, rpt_count=0, rpt_overflow=0, busy=0; prev-sample register=0; window counter=0. Reset wins over every other event, including mid-window and mid-report.
- States: IDLE, MEASURE, REPORT.
- IDLE -> MEASURE: when enable=1 and win_len!=0. On that edge: prev<=nets, acc<=0, ovf<=0, remain<=win_len. If win_len==0, stay in IDLE; no report.
- MEASURE, every cycle:
  - rises = popcount(nets & ~prev).
  - acc <= min(acc+rises, 2^CNT_W-1); ovf<=1 if the sum exceeds that maximum.
  - prev<=nets; remain<=remain-1.
- MEASURE -> REPORT: when remain==1, after counting that cycle. The window is exactly win_len MEASURE cycles.
- MEASURE -> IDLE (abort): if enable=0 in any MEASURE cycle. acc is discarded, no report; that cycle is not counted.
- REPORT:
  - rpt_valid=1; rpt_count=acc and rpt_overflow=ovf, both held stable while rpt_ready=0.
  - Handshake completes on an edge with rpt_valid=1 and rpt_ready=1.
  - Next state on completion: MEASURE (new window; win_len resampled, prev<=nets, acc<=0) if enable=1, else IDLE.
  - enable=0 during REPORT does not drop the report.
- Latency: rpt_valid rises on the edge that ends the last window cycle, i.e. win_len+1 cycles after the enable-sampling edge.
- rpt_count and rpt_overflow keep their last value outside REPORT; they are not cleared.
- Width rule: adder is CNT_W+1 bits, result clamped to CNT_W. popcount is $clog2(N_NETS+1) bits, zero-extended.
- nets are synchronous to clk. X on nets counts as no transition.

Optional Feature:
- ACT_FALL_EN defined: also count 1->0 transitions, rises + popcount(~nets & prev). rpt_count is then total toggles; the same saturation rule applies.
- ACT_FALL_EN undefined: rising transitions only, matching the gate-model energy convention (energy consumed on 0->1 of the output).
- Ports are identical in both builds.

Decomposition:
- Package act_pkg holds:
  - state typedef act_state_t {IDLE, MEASURE, REPORT};
  - default constants ACT_N_NETS, ACT_CNT_W, ACT_WIN_W;
  - function sat_add(acc, inc).
- Sub-module act_edge_count, combinational: inputs nets and prev; output the per-cycle transition popcount. The ACT_FALL_EN selection lives here.
- The FSM, window counter and accumulator stay in the top level.

Test Plan:
- Reset: hold reset_L=0 for 2 cycles with enable=1 and nets toggling -> rpt_valid=0, rpt_count=0, rpt_overflow=0, busy=0.
- Basic window:
  - Stimulus: win_len=4, nets=00 at start, then FF,00,FF,00; rpt_ready=1.
  - Response: rpt_valid pulses 1 cycle, 5 cycles after start; rpt_count=16; rpt_overflow=0.
- Backpressure: same stimulus as the basic window, rpt_ready=0 for 3 cycles -> rpt_valid and rpt_count=16 held stable; accepted on the 4th cycle; next window starts if enable=1.
- Saturation:
  - Stimulus: CNT_W=4, win_len=8, nets alternating 00/0F starting from 00.
  - Response: 16 rises are clamped, so rpt_count=15 and rpt_overflow=1.
- Abort and zero length:
  - enable->0 in the 2nd MEASURE cycle -> IDLE, no rpt_valid, busy=0.
  - win_len=0 -> stays IDLE.
- ACT_FALL_EN build: basic-window stimulus -> rpt_count=32.
